switch_debounce_conditioner: RTL

Conditions one raw, asynchronous slide-switch or push-button input into a clean, glitch-free level for the Nios II PIO input port (`in_port` of the switch PIO). It synchronises, debounces and edge-detects the input, and keeps edge and glitch statistics for board bring-up. It sits between the FPGA pin and the PIO slave, in the `clk` domain of the Avalon fabric.

---
 rtl/switch_debounce_conditioner.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/switch_debounce_conditioner.sv
// switch_debounce_conditioner
//   Turns one raw, bouncing switch/button pin into a clean level for the
//   switch PIO in_port. The pin is synchronised, debounced by a four-state
//   FSM, and edge-detected. Edge and glitch statistics are kept for bring-up.
//
// Ports
//   clk           system clock (Avalon fabric domain)
//   reset_n       asynchronous, active-low reset
//   switch_raw    pin input; asynchronous to clk and may bounce
//   stats_clear   synchronous clear of edge_count / glitch_count
//   switch_clean  debounced level, taken directly from a state bit
//   rise_pulse    one-cycle pulse on an accepted 0->1 transition
//   fall_pulse    one-cycle pulse on an accepted 1->0 transition
//   edge_count    accepted transitions, wraps 0xFFFF -> 0
//   glitch_count  rejected excursions, saturates at 0xFF
module switch_debounce_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        switch_raw,
    input  logic        stats_clear,
    output logic        switch_clean,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic [15:0] edge_count,
    output logic [7:0]  glitch_count
);

    // Bit 1 is the accepted level, so switch_clean is a plain state flop.
    // Bit 0 marks a pending (WAIT) transition towards the other level.
    localparam logic [1:0] ST_STABLE_LO = 2'b00;
    localparam logic [1:0] ST_WAIT_HI   = 2'b01;
    localparam logic [1:0] ST_STABLE_HI = 2'b10;
    localparam logic [1:0] ST_WAIT_LO   = 2'b11;

    localparam logic [CNT_W-1:0] L_DB_CYC = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_s1, r_s2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise, r_fall;
    logic [15:0]      r_edge_cnt;
    logic [7:0]       r_glitch_cnt;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_diff;
    logic             w_accept;
    logic             w_glitch;

    // Two-flop synchroniser; only r_s2 is used downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= switch_raw;
            r_s2 <= r_s1;
        end
    end

    assign w_diff    = r_s2 ^ r_state[1];
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_glitch    = 1'b0;
        case (r_state)
            ST_STABLE_LO, ST_STABLE_HI: begin
                if (!w_diff) begin
                    w_cnt_nxt = '0;
                end else if (DEBOUNCE_CYCLES == 1) begin
                    w_accept = 1'b1;
                end else begin
                    w_state_nxt = {r_state[1], 1'b1};
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_WAIT_HI, ST_WAIT_LO: begin
                if (!w_diff) begin
                    // Sample fell back to the old level: reject and restart.
                    w_glitch    = 1'b1;
                    w_state_nxt = {r_state[1], 1'b0};
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == L_DB_CYC) begin
                    w_accept = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_accept) begin
            w_state_nxt = {~r_state[1], 1'b0};
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_STABLE_LO;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Direction comes from the level being left.
            r_rise  <= w_accept & ~r_state[1];
            r_fall  <= w_accept &  r_state[1];
        end
    end

    // Clear wins over a same-cycle increment; the event is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cnt   <= '0;
            r_glitch_cnt <= '0;
        end else begin
            if (stats_clear)
                r_edge_cnt <= '0;
            else if (w_accept)
                r_edge_cnt <= r_edge_cnt + 16'd1;

            if (stats_clear)
                r_glitch_cnt <= '0;
            else if (w_glitch && (r_glitch_cnt != 8'hFF))
                r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign switch_clean = r_state[1];
    assign rise_pulse   = r_rise;
    assign fall_pulse   = r_fall;
    assign edge_count   = r_edge_cnt;
    assign glitch_count = r_glitch_cnt;

endmodule
